// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
// Imported by the sequencer and its bus interface.
package fc_seq_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        BIAS,
        DRAIN,
        DONE
    } fc_seq_state_t;

    // Wide enough for OUT_LATENCY values 1..15.
    localparam int LAT_W = 4;

    // ROM holds P weights plus one bias word, so addresses span 0..P.
    function automatic int fc_addr_w(input int height);
        return $clog2(height + 1);
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Bus between the layer sequencer, its upstream producer, the fc_neuron
// array it drives, and the downstream consumer of the layer result.
interface fc_layer_sequencer_if
    import fc_seq_pkg::*;
#(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4
);
    localparam int ADDR_W = fc_addr_w(PREVIOUS_LAYER_HEIGHT);

    logic signed [WORD_SIZE-1:0] data_i;
    logic                        valid_i;
    logic                        ready_o;
    logic signed [WORD_SIZE-1:0] data_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic                        sum_en_o;
    logic                        add_bias_o;
    logic                        valid_o;
    logic                        ready_i;
    logic                        busy_o;

    modport master (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, mem_addr_o, sum_en_o, add_bias_o, valid_o, busy_o
    );

    modport slave (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, mem_addr_o, sum_en_o, add_bias_o, valid_o, busy_o
    );

endinterface

// File: rtl/fc_layer_sequencer.sv
// Streams one activation vector into an fc_neuron array: aligns each word with
// its ROM weight address, issues the bias add, then holds the result valid.
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int OUT_LATENCY           = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    fc_layer_sequencer_if.master bus
);

    localparam int                ADDR_W    = fc_addr_w(PREVIOUS_LAYER_HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PREVIOUS_LAYER_HEIGHT - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(OUT_LATENCY);

    fc_seq_state_t               state;
    logic [ADDR_W-1:0]           count;
    logic [LAT_W-1:0]            lat_cnt;
    logic signed [WORD_SIZE-1:0] data_q;
    logic                        sum_en_q;
    logic                        add_bias_q;
    logic                        valid_q;
    logic                        accept;

    // Gated by reset so no word is taken while the neurons are being cleared.
    assign bus.ready_o = (state == ACCUM) && !reset_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign bus.busy_o  = (count != '0) || (state != ACCUM);

    // count doubles as the ROM address: index of the next word in ACCUM,
    // and it lands on P (the bias word) as the last word is accepted.
    assign bus.mem_addr_o = count;
    assign bus.data_o     = data_q;
    assign bus.sum_en_o   = sum_en_q;
    assign bus.add_bias_o = add_bias_q;
    assign bus.valid_o    = valid_q;

    // NOTE: all state uses non-blocking assignments so every branch below sees
    // the pre-edge values; the pulse outputs get a default of 0 up front so
    // each branch only states when they fire.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ACCUM;
            count      <= '0;
            lat_cnt    <= '0;
            data_q     <= '0;
            sum_en_q   <= 1'b0;
            add_bias_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sum_en_q   <= 1'b0;
            add_bias_q <= 1'b0;

            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        data_q   <= bus.data_i;
                        sum_en_q <= 1'b1;
                        count    <= count + ADDR_W'(1);
                        if (count == LAST_ADDR) begin
                            state <= BIAS;
                        end
                    end
                end

                BIAS: begin
                    add_bias_q <= 1'b1;
                    lat_cnt    <= LAT_LOAD;
                    state      <= DRAIN;
                end

                // Raising valid as the counter steps 1 -> 0 puts valid_o
                // exactly OUT_LATENCY cycles after the add_bias_o pulse.
                DRAIN: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        count   <= '0;
                        state   <= ACCUM;
                    end
                end

                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: instance a (P=4, latency 1) and
// instance b (P=1, latency 3) driven with directed vectors.
module tb_fc_layer_sequencer;
    localparam int WS  = 16;
    localparam int P_A = 4;
    localparam int L_A = 1;
    localparam int P_B = 1;
    localparam int L_B = 3;

    typedef struct {
        logic [WS-1:0] data;
        int            idx;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_sequencer_if #(.WORD_SIZE(WS), .PREVIOUS_LAYER_HEIGHT(P_A)) bus_a ();
    fc_layer_sequencer_if #(.WORD_SIZE(WS), .PREVIOUS_LAYER_HEIGHT(P_B)) bus_b ();

    fc_layer_sequencer #(.WORD_SIZE(WS), .PREVIOUS_LAYER_HEIGHT(P_A), .OUT_LATENCY(L_A)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .bus(bus_a.master));
    fc_layer_sequencer #(.WORD_SIZE(WS), .PREVIOUS_LAYER_HEIGHT(P_B), .OUT_LATENCY(L_B)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .bus(bus_b.master));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected sum_en beats and expected valid_o hold lengths.
    beat_t exp_q[2][$];
    int    vec_q[2][$];

    int exp_idx[2]      = '{0, 0};
    int sum_cnt[2]      = '{0, 0};
    int last_sum_cyc[2] = '{0, 0};
    int bias_cyc[2]     = '{0, 0};
    int hold_cnt[2]     = '{0, 0};
    int prev_addr[2]    = '{0, 0};
    int vectors_done[2] = '{0, 0};
    bit rst_prev[2]     = '{1'b0, 1'b0};
    bit valid_prev[2]   = '{1'b0, 1'b0};
    bit post_done[2]    = '{1'b0, 1'b0};

    task automatic monitor_one(input int i, input logic rst, input logic vin, input logic rdy_in,
                               input logic rdy_out, input logic [WS-1:0] dout, input int addr,
                               input logic sum_en, input logic add_bias, input logic vout,
                               input logic busy);
        string tag = (i == 0) ? "a" : "b";
        int    p   = (i == 0) ? P_A : P_B;
        int    l   = (i == 0) ? L_A : L_B;
        beat_t b;
        int    h;
        if (rst) begin
            check({tag, "_ready_in_reset"}, int'(rdy_out), 0);
            if (rst_prev[i])
                check({tag, "_reset_outputs_zero"},
                      int'(dout) | addr | int'({sum_en, add_bias, vout, busy}), 0);
            exp_q[i].delete();
            vec_q[i].delete();
            exp_idx[i]   = 0;
            sum_cnt[i]   = 0;
            hold_cnt[i]  = 0;
            post_done[i] = 1'b0;
        end else begin
            if (rst_prev[i]) begin
                check({tag, "_ready_after_reset"}, int'(rdy_out), 1);
                check({tag, "_busy_after_reset"}, int'(busy), 0);
            end
            if (post_done[i]) begin
                check({tag, "_ready_after_done"}, int'(rdy_out), 1);
                check({tag, "_valid_cleared"}, int'(vout), 0);
                post_done[i] = 1'b0;
            end
            if (rdy_out) begin
                check({tag, "_addr_next_word"}, addr, exp_idx[i]);
                check({tag, "_busy_accum"}, int'(busy), int'(exp_idx[i] != 0));
                if (vin) exp_idx[i] = (exp_idx[i] == p - 1) ? 0 : exp_idx[i] + 1;
            end
            check({tag, "_bias_sum_overlap"}, int'(sum_en && add_bias), 0);
            if (sum_en) begin
                check({tag, "_sum_en_expected"}, int'(exp_q[i].size() != 0), 1);
                if (exp_q[i].size() != 0) begin
                    b = exp_q[i].pop_front();
                    check({tag, "_beat_data"}, int'(dout), int'(b.data));
                    check({tag, "_beat_addr_prev_cycle"}, prev_addr[i], b.idx);
                end
                sum_cnt[i]++;
                last_sum_cyc[i] = cyc;
            end
            if (add_bias) begin
                check({tag, "_sum_pulses_per_bias"}, sum_cnt[i], p);
                check({tag, "_bias_after_last_sum"}, cyc - last_sum_cyc[i], 1);
                check({tag, "_bias_addr_prev_cycle"}, prev_addr[i], p);
                sum_cnt[i]  = 0;
                bias_cyc[i] = cyc;
            end
            if (vout) begin
                if (!valid_prev[i]) check({tag, "_valid_latency"}, cyc - bias_cyc[i], l);
                check({tag, "_ready_during_valid"}, int'(rdy_out), 0);
                check({tag, "_sum_en_during_valid"}, int'(sum_en), 0);
                hold_cnt[i]++;
                if (rdy_in) begin
                    check({tag, "_result_expected"}, int'(vec_q[i].size() != 0), 1);
                    if (vec_q[i].size() != 0) begin
                        h = vec_q[i].pop_front();
                        check({tag, "_valid_hold_cycles"}, hold_cnt[i], h);
                    end
                    hold_cnt[i]  = 0;
                    post_done[i] = 1'b1;
                    vectors_done[i]++;
                end
            end
        end
        prev_addr[i]  = addr;
        rst_prev[i]   = rst;
        valid_prev[i] = vout;
    endtask

    always @(negedge clk) begin
        monitor_one(0, rst_a, bus_a.valid_i, bus_a.ready_i, bus_a.ready_o, bus_a.data_o,
                    int'(bus_a.mem_addr_o), bus_a.sum_en_o, bus_a.add_bias_o, bus_a.valid_o,
                    bus_a.busy_o);
        monitor_one(1, rst_b, bus_b.valid_i, bus_b.ready_i, bus_b.ready_o, bus_b.data_o,
                    int'(bus_b.mem_addr_o), bus_b.sum_en_o, bus_b.add_bias_o, bus_b.valid_o,
                    bus_b.busy_o);
    end

    task automatic drive_in(input int i, input logic v, input logic [WS-1:0] d);
        if (i == 0) begin
            bus_a.valid_i = v;
            bus_a.data_i  = d;
        end else begin
            bus_b.valid_i = v;
            bus_b.data_i  = d;
        end
    endtask

    function automatic logic ready_of(input int i);
        return (i == 0) ? bus_a.ready_o : bus_b.ready_o;
    endfunction

    function automatic logic handshake_of(input int i);
        return (i == 0) ? (bus_a.valid_o && bus_a.ready_i) : (bus_b.valid_o && bus_b.ready_i);
    endfunction

    function automatic logic valid_of(input int i);
        return (i == 0) ? bus_a.valid_o : bus_b.valid_o;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input int i, input logic [WS-1:0] w, input int k, input int hold);
        int   p   = (i == 0) ? P_A : P_B;
        bit   acc = 1'b0;
        logic r;
        drive_in(i, 1'b1, w);
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            r = ready_of(i);
            @(posedge clk);
            #1;
            if (r) acc = 1'b1;
        end
        check((i == 0) ? "a_word_accepted" : "b_word_accepted", int'(acc), 1);
        if (acc) begin
            exp_q[i].push_back('{data: w, idx: k});
            if (k == p - 1) vec_q[i].push_back(hold);
        end
        drive_in(i, 1'b0, '0);
    endtask

    task automatic wait_handshake(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (handshake_of(i)) seen = 1'b1;
        end
        check((i == 0) ? "a_result_handshake" : "b_result_handshake", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (valid_of(i)) seen = 1'b1;
        end
        check((i == 0) ? "a_result_valid" : "b_result_valid", int'(seen), 1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_in(0, 1'b0, '0);
        drive_in(1, 1'b0, '0);
        bus_a.ready_i = 1'b1;
        bus_b.ready_i = 1'b1;
        tick(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(1);

        // Back-to-back vector, downstream always ready.
        for (int k = 0; k < 4; k++) send_word(0, WS'(k + 1), k, 1);
        wait_handshake(0);

        // Two-cycle upstream bubble between words 2 and 3.
        send_word(0, 16'd1, 0, 1);
        send_word(0, 16'd2, 1, 1);
        tick(2);
        send_word(0, 16'd3, 2, 1);
        send_word(0, 16'd4, 3, 1);
        wait_handshake(0);

        // Downstream stalls 5 cycles once the result is valid.
        bus_a.ready_i = 1'b0;
        send_word(0, 16'd10,   0, 6);
        send_word(0, 16'hFFFB, 1, 6);
        send_word(0, 16'd300,  2, 6);
        send_word(0, 16'h8001, 3, 6);
        wait_valid(0);
        tick(5);
        bus_a.ready_i = 1'b1;
        wait_handshake(0);

        // Reset after two words; the partial vector is dropped.
        send_word(0, 16'd1, 0, 1);
        send_word(0, 16'd2, 1, 1);
        rst_a = 1'b1;
        tick(3);
        rst_a = 1'b0;
        tick(1);
        for (int k = 0; k < 4; k++) send_word(0, WS'(k + 5), k, 1);
        wait_handshake(0);

        // Single-word layer with a three-cycle output latency.
        send_word(1, 16'h7FFF, 0, 1);
        wait_handshake(1);
        send_word(1, 16'h8000, 0, 1);
        wait_handshake(1);

        tick(5);
        check("a_beats_drained",   exp_q[0].size(), 0);
        check("b_beats_drained",   exp_q[1].size(), 0);
        check("a_results_drained", vec_q[0].size(), 0);
        check("b_results_drained", vec_q[1].size(), 0);
        check("a_vectors_done",    vectors_done[0], 4);
        check("b_vectors_done",    vectors_done[1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
